// File: rtl/riscv_ctrl_pkg.sv
// Shared fetch-control definitions: PC scheduler state encoding, address defaults and
// the control-transfer opcodes that the predictor, decoder and PC scheduler all use.
package riscv_ctrl_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones, never wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC scheduler: arbitrates mispredict / prediction / stall / PC+4, parks a
// prediction that lands during a stall, and drives the pipeline flushes and perf counters.
module pc_redirect_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int              BOOT_CYCLES = 2,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             pred_valid,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             resolve_valid,
  input  logic             resolve_mispred,
  input  logic [XLEN-1:0]  resolve_target,
  output logic [XLEN-1:0]  pc_f,
  output logic             fetch_valid,
  output logic             flush_fd,
  output logic             flush_de,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  pc_state_t         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic              mispredict;
  logic              active;

  // Instruction fetch is halfword-aligned at minimum, so bit 0 never reaches the PC.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] t);
    return {t[XLEN-1:1], 1'b0};
  endfunction

  assign mispredict = resolve_valid & resolve_mispred;
  assign active     = (state_q != ST_BOOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      boot_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      boot_cnt_q    <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    boot_cnt_d    = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mispredict) begin
          pc_d = align_pc(resolve_target);
        end else if (stall_f) begin
          if (pred_valid) begin
            pend_target_d = pred_target;
            state_d       = ST_PEND;
          end
        end else if (pred_valid) begin
          pc_d = align_pc(pred_target);
        end else begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      ST_PEND: begin
        // A mispredict supersedes the parked prediction; it is simply abandoned.
        if (mispredict) begin
          pc_d    = align_pc(resolve_target);
          state_d = ST_RUN;
        end else if (!stall_f) begin
          pc_d    = align_pc(pend_target_q);
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = active;
    flush_fd    = active & mispredict;
    flush_de    = active & mispredict;
  end

  assign pc_f = pc_q;

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (active & resolve_valid),
    .count (br_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (active & mispredict),
    .count (mis_count)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_redirect_ctrl;

  localparam int XLEN        = 32;
  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall_f = 1'b0;
  logic             pred_valid = 1'b0;
  logic [XLEN-1:0]  pred_target = '0;
  logic             resolve_valid = 1'b0;
  logic             resolve_mispred = 1'b0;
  logic [XLEN-1:0]  resolve_target = '0;
  logic [XLEN-1:0]  pc_f;
  logic             fetch_valid;
  logic             flush_fd;
  logic             flush_de;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_boot_left;
  bit          m_pend;
  logic [31:0] m_pend_t;
  logic [31:0] m_pc;
  int          m_br;
  int          m_mis;

  pc_redirect_ctrl #(
    .XLEN        (XLEN),
    .RESET_PC    (32'h0),
    .BOOT_CYCLES (BOOT_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .pred_valid      (pred_valid),
    .pred_target     (pred_target),
    .resolve_valid   (resolve_valid),
    .resolve_mispred (resolve_mispred),
    .resolve_target  (resolve_target),
    .pc_f            (pc_f),
    .fetch_valid     (fetch_valid),
    .flush_fd        (flush_fd),
    .flush_de        (flush_de),
    .br_count        (br_count),
    .mis_count       (mis_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_add(input int v, input bit inc);
    return (inc && v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_boot_left = BOOT_CYCLES;
    m_pend      = 1'b0;
    m_pend_t    = '0;
    m_pc        = 32'h0;
    m_br        = 0;
    m_mis       = 0;
  endtask

  task automatic check_model(input string tag);
    bit fv;
    bit fl;
    fv = (m_boot_left == 0);
    fl = fv && resolve_valid && resolve_mispred;
    check({tag, "_pc"},    pc_f,                m_pc);
    check({tag, "_fv"},    32'(fetch_valid),    32'(fv));
    check({tag, "_fl_fd"}, 32'(flush_fd),       32'(fl));
    check({tag, "_fl_de"}, 32'(flush_de),       32'(fl));
    check({tag, "_br"},    32'(br_count),       32'(m_br));
    check({tag, "_mis"},   32'(mis_count),      32'(m_mis));
  endtask

  // Applies the fetch rules to the model for the edge that just happened.
  task automatic model_step(input bit st, input bit pv, input logic [31:0] pt,
                            input bit rv, input bit rm, input logic [31:0] rt);
    bit misp;
    misp = rv && rm;
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else begin
      m_br  = sat_add(m_br, rv);
      m_mis = sat_add(m_mis, misp);
      if (misp) begin
        m_pc   = rt & ~32'h1;
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (!st) begin
          m_pc   = m_pend_t & ~32'h1;
          m_pend = 1'b0;
        end
      end else if (st) begin
        if (pv) begin
          m_pend   = 1'b1;
          m_pend_t = pt;
        end
      end else if (pv) begin
        m_pc = pt & ~32'h1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic cycle(input string tag, input bit st, input bit pv, input logic [31:0] pt,
                       input bit rv, input bit rm, input logic [31:0] rt);
    stall_f         = st;
    pred_valid      = pv;
    pred_target     = pt;
    resolve_valid   = rv;
    resolve_mispred = rm;
    resolve_target  = rt;
    #1;
    check_model(tag);
    @(posedge clk);
    model_step(st, pv, pt, rv, rm, rt);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    stall_f = 1'b0; pred_valid = 1'b0; resolve_valid = 1'b0; resolve_mispred = 1'b0;
    model_reset();
    #1;
    check_model("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    sync_reset();

    // Boot: two invalid cycles, then 0x0, 0x4, 0x8 ...
    idle("boot", 2);
    check("boot_done_fv", 32'(fetch_valid), 32'd1);
    check("boot_first_pc", pc_f, 32'h0);
    idle("run", 4);
    check("run_pc_10", pc_f, 32'h10);

    // Mispredict to an odd target: flush now, aligned PC next.
    cycle("misp", 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h41);
    check("misp_pc", pc_f, 32'h40);
    check("misp_cnt", 32'(mis_count), 32'd1);
    check("misp_br", 32'(br_count), 32'd1);

    // Prediction arriving in a three-cycle stall is parked, then taken.
    cycle("stall1", 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0);
    cycle("stall2", 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, '0);
    cycle("stall3", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check("stall_held", pc_f, 32'h40);
    cycle("pend_rel", 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, '0);
    check("pend_taken", pc_f, 32'h100);
    idle("after_pend", 1);
    check("pend_plus4", pc_f, 32'h104);

    // Mispredict while parked and stalled discards the parked target.
    cycle("pend2", 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0);
    cycle("pend_misp", 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h200);
    check("pend_misp_pc", pc_f, 32'h200);
    idle("pend_misp_run", 1);
    check("pend_discard", pc_f, 32'h204);

    // Counter saturation.
    for (int i = 0; i < 20; i++)
      cycle("sat", 1'b0, 1'b0, '0, 1'b1, 1'b1, {$urandom_range(0, 255), 4'h0});
    check("sat_mis", 32'(mis_count), 32'(SAT));
    check("sat_br", 32'(br_count), 32'(SAT));

    // Asynchronous reset in the middle of a cycle while parked.
    cycle("pend3", 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc_f, 32'h0);
    check("arst_fv", 32'(fetch_valid), 32'd0);
    check("arst_br", 32'(br_count), 32'd0);
    check("arst_mis", 32'(mis_count), 32'd0);
    @(negedge clk);
    sync_reset();
    idle("arst_boot", 3);
    check("arst_no_pend", pc_f, 32'h4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        sync_reset();
      end else begin
        cycle("rnd",
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3,
              $urandom,
              $urandom_range(0, 9) < 2,
              $urandom_range(0, 1) == 1,
              $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
